// File: rtl/one_four_demux.sv
`default_nettype none
// ============================================================================
// Module   : one_four_demux
// Brief    : Registered 1-to-4 demultiplexer with per-channel valid strobes
//            and saturating transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
module one_four_demux #(
    parameter int WIDTH      = 3,
    parameter int CNT_W      = 8,
    parameter int HOLD_UNSEL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [WIDTH-1:0] r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];
    logic [3:0]       r_valid;
    logic [3:0]       w_sel_hot;

    // One-hot of the channel taking a transfer this cycle; zero when idle.
    always_comb begin
        w_sel_hot = 4'b0000;
        if (in_valid) begin
            w_sel_hot = 4'b0001 << sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            r_valid <= w_sel_hot;
            for (int k = 0; k < 4; k++) begin
                if (w_sel_hot[k]) begin
                    r_data[k] <= in;
                end else if (in_valid && (HOLD_UNSEL == 0)) begin
                    r_data[k] <= '0;
                end

                // Clear beats a same-cycle increment; saturate instead of wrap.
                if (cnt_clr) begin
                    r_cnt[k] <= '0;
                end else if (w_sel_hot[k] && (r_cnt[k] != c_cnt_max)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign a         = r_data[0];
    assign b         = r_data[1];
    assign c         = r_data[2];
    assign d         = r_data[3];
    assign out_valid = r_valid;
    assign cnt_a     = r_cnt[0];
    assign cnt_b     = r_cnt[1];
    assign cnt_c     = r_cnt[2];
    assign cnt_d     = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_one_four_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_one_four_demux
// Brief    : Self-checking bench: three configurations driven in parallel,
//            table vectors, hand sequences and random traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_one_four_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din;
    logic [1:0] sel;
    logic       in_valid;
    logic       cnt_clr;

    logic [2:0] dd [3][4];
    logic [3:0] vv [3];
    logic [7:0] cc [3][4];
    logic [3:0] cnt2 [4];

    int checks = 0;
    int errors = 0;

    // Reference state per configuration: 0 = default, 1 = HOLD_UNSEL, 2 = CNT_W=4
    int m_data  [3][4];
    int m_cnt   [3][4];
    int m_valid [3];
    int c_hold  [3] = '{0, 1, 0};
    int c_cw    [3] = '{8, 8, 4};

    always #5 clk = ~clk;

    one_four_demux #(.WIDTH(3), .CNT_W(8), .HOLD_UNSEL(0)) u_dut0 (
        .clk(clk), .rst(rst), .in(din), .sel(sel), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .a(dd[0][0]), .b(dd[0][1]), .c(dd[0][2]), .d(dd[0][3]), .out_valid(vv[0]),
        .cnt_a(cc[0][0]), .cnt_b(cc[0][1]), .cnt_c(cc[0][2]), .cnt_d(cc[0][3])
    );

    one_four_demux #(.WIDTH(3), .CNT_W(8), .HOLD_UNSEL(1)) u_dut1 (
        .clk(clk), .rst(rst), .in(din), .sel(sel), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .a(dd[1][0]), .b(dd[1][1]), .c(dd[1][2]), .d(dd[1][3]), .out_valid(vv[1]),
        .cnt_a(cc[1][0]), .cnt_b(cc[1][1]), .cnt_c(cc[1][2]), .cnt_d(cc[1][3])
    );

    one_four_demux #(.WIDTH(3), .CNT_W(4), .HOLD_UNSEL(0)) u_dut2 (
        .clk(clk), .rst(rst), .in(din), .sel(sel), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .a(dd[2][0]), .b(dd[2][1]), .c(dd[2][2]), .d(dd[2][3]), .out_valid(vv[2]),
        .cnt_a(cnt2[0]), .cnt_b(cnt2[1]), .cnt_c(cnt2[2]), .cnt_d(cnt2[3])
    );

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cc[2][k] = {4'b0000, cnt2[k]};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Spec rules applied directly to the sampled inputs of one edge.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int max_cnt;
            max_cnt = (1 << c_cw[k]) - 1;
            if (rst) begin
                m_valid[k] = 0;
                for (int ch = 0; ch < 4; ch++) begin
                    m_data[k][ch] = 0;
                    m_cnt[k][ch]  = 0;
                end
            end else begin
                m_valid[k] = in_valid ? (1 << sel) : 0;
                for (int ch = 0; ch < 4; ch++) begin
                    if (in_valid && ch == int'(sel)) m_data[k][ch] = int'(din);
                    else if (in_valid && c_hold[k] == 0) m_data[k][ch] = 0;
                    if (cnt_clr) m_cnt[k][ch] = 0;
                    else if (in_valid && ch == int'(sel))
                        m_cnt[k][ch] = (m_cnt[k][ch] + 1 > max_cnt) ? max_cnt : m_cnt[k][ch] + 1;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cfg%0d.valid", k), int'(vv[k]), m_valid[k]);
            for (int ch = 0; ch < 4; ch++) begin
                chk($sformatf("cfg%0d.data%0d", k, ch), int'(dd[k][ch]), m_data[k][ch]);
                chk($sformatf("cfg%0d.cnt%0d", k, ch), int'(cc[k][ch]), m_cnt[k][ch]);
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] i, input logic [1:0] s,
                        input logic v, input logic cl);
        rst = r; din = i; sel = s; in_valid = v; cnt_clr = cl;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r;
        logic [2:0] i;
        logic [1:0] s;
        logic       v;
        logic       cl;
        int         ea, eb, ec, ed;
        int         ev;
        int         ca, cb, cc_, cd;
    } vec_t;

    vec_t tbl [16];

    initial begin
        rst = 1'b1; din = '0; sel = '0; in_valid = 1'b0; cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                m_data[k][ch] = 0;
                m_cnt[k][ch]  = 0;
            end
        end

        // Expected values for the default configuration (HOLD_UNSEL=0, CNT_W=8).
        //              r  in   sel   v  clr  a  b  c  d  ov   cnt a b c d
        tbl[0]  = '{1'b1, 3'd7, 2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{1'b1, 3'd7, 2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[2]  = '{1'b0, 3'd4, 2'd0, 1'b1, 1'b0, 4, 0, 0, 0, 1,  1, 0, 0, 0};
        tbl[3]  = '{1'b0, 3'd6, 2'd2, 1'b1, 1'b0, 0, 0, 6, 0, 4,  1, 0, 1, 0};
        tbl[4]  = '{1'b0, 3'd2, 2'd1, 1'b1, 1'b0, 0, 2, 0, 0, 2,  1, 1, 1, 0};
        tbl[5]  = '{1'b0, 3'd3, 2'd1, 1'b1, 1'b0, 0, 3, 0, 0, 2,  1, 2, 1, 0};
        tbl[6]  = '{1'b0, 3'd5, 2'd3, 1'b1, 1'b0, 0, 0, 0, 5, 8,  1, 2, 1, 1};
        tbl[7]  = '{1'b0, 3'd7, 2'd2, 1'b1, 1'b0, 0, 0, 7, 0, 4,  1, 2, 2, 1};
        tbl[8]  = '{1'b0, 3'd5, 2'd3, 1'b1, 1'b0, 0, 0, 0, 5, 8,  1, 2, 2, 2};
        tbl[9]  = '{1'b0, 3'd1, 2'd0, 1'b0, 1'b0, 0, 0, 0, 5, 0,  1, 2, 2, 2};
        tbl[10] = '{1'b0, 3'd6, 2'd1, 1'b0, 1'b0, 0, 0, 0, 5, 0,  1, 2, 2, 2};
        tbl[11] = '{1'b0, 3'd2, 2'd2, 1'b0, 1'b0, 0, 0, 0, 5, 0,  1, 2, 2, 2};
        tbl[12] = '{1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 0, 0, 0, 5, 0,  0, 0, 0, 0};
        tbl[13] = '{1'b0, 3'd6, 2'd0, 1'b1, 1'b0, 6, 0, 0, 0, 1,  1, 0, 0, 0};
        tbl[14] = '{1'b1, 3'd3, 2'd1, 1'b1, 1'b0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[15] = '{1'b0, 3'd1, 2'd1, 1'b1, 1'b0, 0, 1, 0, 0, 2,  0, 1, 0, 0};

        for (int n = 0; n < 16; n++) begin
            step(tbl[n].r, tbl[n].i, tbl[n].s, tbl[n].v, tbl[n].cl);
            chk($sformatf("vec%0d.a", n),   int'(dd[0][0]), tbl[n].ea);
            chk($sformatf("vec%0d.b", n),   int'(dd[0][1]), tbl[n].eb);
            chk($sformatf("vec%0d.c", n),   int'(dd[0][2]), tbl[n].ec);
            chk($sformatf("vec%0d.d", n),   int'(dd[0][3]), tbl[n].ed);
            chk($sformatf("vec%0d.ov", n),  int'(vv[0]),    tbl[n].ev);
            chk($sformatf("vec%0d.cnt", n),
                int'({cc[0][3], cc[0][2], cc[0][1], cc[0][0]}),
                (tbl[n].cd << 24) | (tbl[n].cc_ << 16) | (tbl[n].cb << 8) | tbl[n].ca);
        end

        // Held channels accumulate when unselected outputs keep their value.
        step(1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 3'd4, 2'd0, 1'b1, 1'b0);
        step(1'b0, 3'd6, 2'd2, 1'b1, 1'b0);
        chk("hold.a", int'(dd[1][0]), 4);
        chk("hold.b", int'(dd[1][1]), 0);
        chk("hold.c", int'(dd[1][2]), 6);
        chk("hold.d", int'(dd[1][3]), 0);
        chk("nohold.a", int'(dd[0][0]), 0);

        // Saturation on the 4-bit counter, then clear racing a transfer.
        step(1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) step(1'b0, 3'(n), 2'd1, 1'b1, 1'b0);
        chk("sat.cnt_b", int'(cnt2[1]), 15);
        chk("sat.cnt_b8", int'(cc[0][1]), 20);
        step(1'b0, 3'd5, 2'd1, 1'b1, 1'b1);
        chk("clr.cnt_b", int'(cnt2[1]), 0);
        chk("clr.b", int'(dd[2][1]), 5);
        chk("clr.ov", int'(vv[2]), 2);

        // Random traffic with occasional reset and counter clear.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), 3'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/one_four_demux.md
Name: one_four_demux

Overview:
Registered 1-to-4 demultiplexer. It routes a WIDTH-bit data word to one of four output channels (a, b, c, d) chosen by a 2-bit select. Each output channel has a valid strobe and a saturating transfer counter. It sits between a single producer and four consumers; all outputs update on the rising clock edge, one cycle after the input.

Parameters:
WIDTH, 3, data width of the input and of each output channel
CNT_W, 8, width of each per-channel transfer counter
HOLD_UNSEL, 0, 0 = unselected data outputs clear to 0 on a transfer; 1 = unselected data outputs keep their value

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
in  input  WIDTH  data word to route
sel  input  2  channel select: 0=a, 1=b, 2=c, 3=d
in_valid  input  1  marks in/sel as a transfer this cycle
cnt_clr  input  1  synchronous clear of all four counters
a  output  WIDTH  channel 0 data (registered)
b  output  WIDTH  channel 1 data (registered)
c  output  WIDTH  channel 2 data (registered)
d  output  WIDTH  channel 3 data (registered)
out_valid  output  4  one-hot strobe; bit0=a ... bit3=d
cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  transfers delivered per channel

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: while rst=1 at a rising edge, these clear to 0: a, b, c, d, out_valid and all counters. rst has priority over all other inputs.
- Latency: exactly 1 cycle. in, sel and in_valid sampled at edge N appear on the outputs after edge N.
- Transfer (in_valid=1):
  - Channel k=sel loads in.
  - out_valid becomes one-hot with bit k set for one cycle.
  - HOLD_UNSEL=0: the other three data outputs load 0. This matches combinational demux semantics.
  - HOLD_UNSEL=1: the other three data outputs keep their value.
- Idle (in_valid=0):
  - out_valid=4'b0000.
  - All data outputs hold their value.
  - Counters are unchanged.
- Back-to-back transfers: there is no stall or backpressure. A transfer is accepted every cycle in_valid=1. Consecutive transfers may target the same channel or different channels.
- Counters:
  - The counter for channel sel increments by 1 on each transfer.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- cnt_clr=1: all counters load 0 at the edge. If a transfer occurs in the same cycle, cnt_clr wins: the counter is 0, but the data and out_valid update normally.
- Width rules: the data path copies in unchanged, with no extension or truncation. sel is fully decoded, so there is no illegal value.
- Reset mid-operation: a transfer presented in the reset cycle is discarded and is not counted. The first transfer is accepted on the first edge with rst=0.
- Outputs are driven only from registers, with no combinational path from inputs to outputs.

Test Plan:
1. Reset: rst=1 for 2 cycles with in=7, sel=2, in_valid=1 -> a=b=c=d=0, out_valid=0, all counters 0.
2. Routing sweep, HOLD_UNSEL=0, in_valid=1 every cycle:
   - (in=4, sel=0) -> a=4, others 0, out_valid=0001
   - (6, 2) -> c=6, others 0, out_valid=0100
   - (2, 1) -> b=2
   - (3, 1) -> b=3
   - (5, 3) -> d=5, out_valid=1000
   - (7, 2) -> c=7, others 0
   - Each response appears one cycle after the input.
   - Resulting counts: cnt_a=1, cnt_b=2, cnt_c=2, cnt_d=1.
3. Idle hold: after sending (in=5, sel=3), drop in_valid for 3 cycles while toggling in and sel -> d stays 5, out_valid=0, counters unchanged.
4. HOLD_UNSEL=1: send (4, 0) then (6, 2) -> a=4 and c=6 simultaneously; b=d=0.
5. Counter saturation and clear (CNT_W=4):
   - 20 transfers to sel=1 -> cnt_b=15.
   - Then cnt_clr=1 in the same cycle as a transfer to sel=1 -> cnt_b=0 while b updates and out_valid=0010.
6. Reset mid-stream: apply rst=1 during a burst of transfers -> all outputs 0 on the next edge. The transfer in the reset cycle is not counted, and transfers resume normally after rst deasserts.
